// File: rtl/bolt_pkg.sv
// Shared fetch-path types: redirect kinds, fetch FSM states and base widths.
package bolt_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_BR,
    REDIR_JAL,
    REDIR_JALR
  } redir_e;

  typedef enum logic {
    FS_RUN,
    FS_HALT
  } fetch_state_e;

endpackage

// File: rtl/ifu_ibuf.sv
// In-order instruction buffer holding {pc, instr}; flush empties it in one cycle.
module ifu_ibuf #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; the head is masked while empty so decode sees zeros.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ifu_fetch_unit.sv
// Instruction fetch unit: PC generation, credit-limited imem requests, stale-response drop and decode buffer.
module ifu_fetch_unit #(
  parameter int              XLEN       = bolt_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IBUF_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [bolt_pkg::ILEN-1:0] imem_rsp_data,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [bolt_pkg::ILEN-1:0] instr_data,
  output logic [XLEN-1:0]          instr_pc,
  input  logic                     ibranch,
  input  logic                     sb_type,
  input  logic                     uj_type,
  input  logic                     i_typej,
  input  logic [XLEN-1:0]          redir_pc,
  input  logic [XLEN-1:0]          rs1_data,
  input  logic [XLEN-1:0]          imm,
  output logic                     fetch_err,
  output logic [XLEN-1:0]          fetch_err_pc
);

  import bolt_pkg::*;

  localparam int CW = $clog2(IBUF_DEPTH) + 1;

  fetch_state_e          state;
  fetch_state_e          state_nxt;
  redir_e                rkind;
  logic                  redir;
  logic                  misalign;
  logic                  credit_ok;
  logic                  req_fire;
  logic                  rsp_live;
  logic                  push;
  logic                  pop;
  logic                  buf_full;
  logic                  buf_empty;
  logic [XLEN-1:0]       fetch_pc;
  logic [XLEN-1:0]       rsp_pc;
  logic [XLEN-1:0]       target;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         drop;
  logic [CW-1:0]         occ;
  logic [XLEN+ILEN-1:0]  head;

  always_comb begin
    rkind = REDIR_NONE;
    if (sb_type && ibranch) rkind = REDIR_BR;
    else if (uj_type)       rkind = REDIR_JAL;
    else if (i_typej)       rkind = REDIR_JALR;
  end

  assign redir    = (rkind != REDIR_NONE);
  assign target   = (rkind == REDIR_JALR) ? ((rs1_data + imm) & ~XLEN'(1))
                                          : (redir_pc + (imm << 1));
  assign misalign = target[1];

  // Holding off while a full credit's worth of stale responses is pending keeps drop within its width.
  assign credit_ok      = ((inflight + occ) < CW'(IBUF_DEPTH)) && (drop < CW'(IBUF_DEPTH));
  assign imem_req_valid = !rst && (state == FS_RUN) && !redir && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_live = imem_rsp_valid && (drop == '0);
  assign push     = rsp_live && !redir && (!buf_full || pop);
  assign pop      = instr_valid && instr_ready && !redir;

  always_comb begin
    state_nxt = state;
    if (redir) state_nxt = misalign ? FS_HALT : FS_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FS_RUN;
      fetch_pc     <= RESET_PC;
      rsp_pc       <= RESET_PC;
      inflight     <= '0;
      drop         <= '0;
      fetch_err    <= 1'b0;
      fetch_err_pc <= '0;
    end else begin
      state     <= state_nxt;
      fetch_err <= redir && misalign;
      if (redir && misalign) fetch_err_pc <= target;
      if (redir) begin
        // Everything still outstanding belongs to the old path and will be discarded on return.
        inflight <= '0;
        drop     <= drop + inflight - CW'(imem_rsp_valid);
        if (!misalign) begin
          fetch_pc <= target;
          rsp_pc   <= target;
        end
      end else begin
        inflight <= inflight + CW'(req_fire) - CW'(rsp_live);
        drop     <= drop - CW'(imem_rsp_valid && (drop != '0));
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_live) rsp_pc   <= rsp_pc + XLEN'(4);
      end
    end
  end

  ifu_ibuf #(
    .DEPTH (IBUF_DEPTH),
    .WIDTH (XLEN + ILEN)
  ) u_ibuf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (pop),
    .flush     (redir),
    .head_data (head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (occ)
  );

  assign instr_valid = !buf_empty;
  assign {instr_pc, instr_data} = head;

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Bench for ifu_fetch_unit: in-order memory model, PC reference scoreboard, vector table and directed corner cases.
module tb_ifu_fetch_unit;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;
  logic        ibranch, sb_type, uj_type, i_typej;
  logic [31:0] redir_pc, rs1_data, imm;
  logic        fetch_err;
  logic [31:0] fetch_err_pc;

  ifu_fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC), .IBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
    .ibranch(ibranch), .sb_type(sb_type), .uj_type(uj_type), .i_typej(i_typej),
    .redir_pc(redir_pc), .rs1_data(rs1_data), .imm(imm),
    .fetch_err(fetch_err), .fetch_err_pc(fetch_err_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct {
    logic rdy_req; logic rdy_instr;
    logic exp_rv; logic [31:0] exp_addr; logic exp_iv; logic [31:0] exp_pc;
  } vec_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, n_hs = 0, n_pop = 0, n_rv = 0, n_iv = 0;
  int          lat = 1;
  bit          rnd_mem = 1'b0;
  bit          tb_halt, err_exp, stall_prev;
  logic [31:0] ref_req_pc, err_pc_exp, stall_addr;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] ref_target();
    if ((sb_type && ibranch) || uj_type) return redir_pc + (imm << 1);
    return (rs1_data + imm) & 32'hFFFF_FFFE;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_redir();
    sb_type = 1'b0; ibranch = 1'b0; uj_type = 1'b0; i_typej = 1'b0;
  endtask

  // One clock: score at negedge, advance, then present the memory response for the new cycle.
  task automatic cycle();
    bit          redir_now;
    logic [31:0] t;
    exp_t        e;
    @(negedge clk);
    redir_now = (sb_type && ibranch) || uj_type || i_typej;
    err_exp   = 1'b0;
    if (imem_req_valid) n_rv++;
    if (instr_valid)    n_iv++;
    if (stall_prev && !redir_now) begin
      chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
      chk("req_hold_addr", imem_req_addr, stall_addr);
    end
    stall_prev = imem_req_valid && !imem_req_ready;
    stall_addr = imem_req_addr;
    if (redir_now) begin
      chk("redir_noreq", 32'(imem_req_valid), 32'd0);
      t = ref_target();
      exp_q.delete();
      if (t[1]) begin tb_halt = 1'b1; err_exp = 1'b1; err_pc_exp = t; end
      else begin tb_halt = 1'b0; ref_req_pc = t; end
    end else begin
      if (tb_halt && imem_req_valid) chk("halt_noreq", 32'(imem_req_valid), 32'd0);
      if (imem_req_valid && imem_req_ready) begin
        n_hs++;
        chk("req_addr", imem_req_addr, ref_req_pc);
        exp_q.push_back('{ref_req_pc, mdata(ref_req_pc)});
        ref_req_pc += 32'd4;
      end
      if (instr_valid && instr_ready) begin
        n_pop++;
        chk("pop_has_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc, e.pc);
          chk("instr_data", instr_data, e.data);
        end
      end
    end
    if (imem_rsp_valid && mem_q.size() != 0) void'(mem_q.pop_front());
    if (imem_req_valid && imem_req_ready)
      mem_q.push_back('{imem_req_addr, cyc + (rnd_mem ? int'($urandom_range(1, 4)) : lat)});
    @(posedge clk); #1;
    cyc++;
    chk("fetch_err", 32'(fetch_err), 32'(err_exp));
    if (err_exp) chk("fetch_err_pc", fetch_err_pc, err_pc_exp);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc && !(rnd_mem && $urandom_range(0, 3) == 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mdata(mem_q[0].addr);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    clear_redir();
    redir_pc = '0; rs1_data = '0; imm = '0;
    mem_q.delete(); exp_q.delete();
    ref_req_pc = RPC; tb_halt = 1'b0; err_exp = 1'b0; stall_prev = 1'b0;
    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RPC);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_data", instr_data, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("rst_fetch_err_pc", fetch_err_pc, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_pops(input int target, input int bound);
    int k;
    k = 0;
    while (n_pop < target && k < bound) begin
      cycle();
      k++;
    end
    chk("pop_progress", 32'(n_pop >= target), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[9];
    int          h0, p0, iv0, rv0;
    logic [31:0] a0;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd12};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 32'd24, 1'b1, 32'd16};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'd24, 1'b1, 32'd16};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 32'd28, 1'b1, 32'd20};

    imem_req_ready = 1'b0; instr_ready = 1'b0;
    do_reset();

    // Back-to-back fetch with a one-cycle memory
    lat = 1;
    for (int i = 0; i < 9; i++) begin
      imem_req_ready = tbl[i].rdy_req;
      instr_ready    = tbl[i].rdy_instr;
      #1;
      chk($sformatf("t%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].exp_rv));
      chk($sformatf("t%0d_req_addr", i), imem_req_addr, tbl[i].exp_addr);
      chk($sformatf("t%0d_instr_valid", i), 32'(instr_valid), 32'(tbl[i].exp_iv));
      chk($sformatf("t%0d_instr_pc", i), instr_pc, tbl[i].exp_pc);
      chk($sformatf("t%0d_instr_data", i), instr_data, tbl[i].exp_iv ? mdata(tbl[i].exp_pc) : 32'd0);
      cycle();
    end

    // Decode stalled: credit limits to DEPTH requests
    do_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b0;
    h0 = n_hs;
    repeat (12) cycle();
    chk("credit_hs_count", 32'(n_hs - h0), 32'(DEPTH));
    #1;
    chk("credit_blocked", 32'(imem_req_valid), 32'd0);
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    #1;
    chk("credit_reopen", 32'(imem_req_valid), 32'd1);

    // Taken branch with two requests in flight
    do_reset();
    lat = 5; imem_req_ready = 1'b1; instr_ready = 1'b0;
    h0 = n_hs;
    cycle(); cycle();
    chk("br_two_inflight", 32'(n_hs - h0), 32'd2);
    sb_type = 1'b1; ibranch = 1'b1; redir_pc = 32'h100; imm = 32'h10;
    cycle();
    clear_redir();
    imem_req_ready = 1'b0;
    #1;
    chk("br_req_valid", 32'(imem_req_valid), 32'd1);
    chk("br_req_addr", imem_req_addr, 32'h120);
    iv0 = n_iv;
    repeat (8) cycle();
    chk("br_stale_dropped", 32'(n_iv - iv0), 32'd0);
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    wait_pops(n_pop + 4, 100);

    // Misaligned JALR halts fetch until an aligned JAL
    lat = 2;
    i_typej = 1'b1; rs1_data = 32'h2001; imm = 32'h2;
    cycle();
    clear_redir();
    rv0 = n_rv;
    repeat (6) cycle();
    chk("halt_no_requests", 32'(n_rv - rv0), 32'd0);
    chk("halt_err_pc_held", fetch_err_pc, 32'h2002);
    uj_type = 1'b1; redir_pc = 32'h2800; imm = 32'h400;
    cycle();
    clear_redir();
    #1;
    chk("jal_req_valid", 32'(imem_req_valid), 32'd1);
    chk("jal_req_addr", imem_req_addr, 32'h3000);
    wait_pops(n_pop + 3, 100);

    // Not-taken branch keeps streaming; branch wins over JAL/JALR
    lat = 1;
    repeat (8) cycle();
    sb_type = 1'b1; ibranch = 1'b0;
    h0 = n_hs;
    repeat (5) cycle();
    chk("sb_not_taken_hs", 32'(n_hs - h0), 32'd5);
    sb_type = 1'b1; ibranch = 1'b1; uj_type = 1'b1; i_typej = 1'b1;
    redir_pc = 32'h400; imm = 32'h20; rs1_data = 32'h8000;
    cycle();
    clear_redir();
    #1;
    chk("prio_req_addr", imem_req_addr, 32'h440);
    wait_pops(n_pop + 3, 100);

    // Memory stalls the request for three cycles
    imem_req_ready = 1'b0;
    #1;
    a0 = imem_req_addr;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(imem_req_valid), 32'd1);
      chk("stall_addr", imem_req_addr, a0);
      cycle();
    end
    imem_req_ready = 1'b1;
    h0 = n_hs;
    cycle();
    chk("stall_release", 32'(n_hs - h0), 32'd1);

    // Random ready/latency with occasional taken branches
    rnd_mem = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 800; i++) begin
      imem_req_ready = ($urandom_range(0, 9) < 7);
      instr_ready    = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 49) == 0) begin
        sb_type = 1'b1; ibranch = 1'b1;
        redir_pc = $urandom & 32'h000F_FFFC;
        imm = 32'($urandom_range(0, 255) * 2);
      end
      cycle();
      clear_redir();
    end
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    wait_pops(n_pop + 10, 200);
    chk("random_progress", 32'(n_pop - p0 > 150), 32'd1);

    // Reset in the middle of traffic
    instr_ready = 1'b0;
    repeat (3) cycle();
    do_reset();
    rnd_mem = 1'b0;
    #1;
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_rst_req_addr", imem_req_addr, RPC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
